clk_ratio_meter: RTL and testbench

Fast-clock-domain monitor for the divided clock produced by `clk_division`. It synchronises the slow clock into `clk`, detects its edges and measures its period and high time in `clk` cycles. It declares lock once the measured period is stable and flags a stopped divided clock. It sits beside the divider as its checker and consumer, and feeds ratio status to control logic and testbenches.

---
 rtl/clk_meas_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/clk_ratio_meter.sv | 131 +++++++++++++
 tb/tb_clk_ratio_meter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the divided-clock ratio meter.
// Imported by the meter top level and its testbench.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } meas_state_t;

  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level with edge detection.
// Outputs are derived only from flops, so they are glitch-free in clk.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~s_d_q;
  assign fall  = ~level & s_d_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a divided clock in fast-clock cycles,
// declares lock on a stable period and flags a stopped input.
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clk_div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_COUNT);

  meas_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [MW-1:0]    match_q, match_d;
  logic             pv_q, pv_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic level_w, rise_w, fall_w, sat_w;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(clk_div_in),
    .level  (level_w),
    .rise   (rise_w),
    .fall   (fall_w)
  );

  assign sat_w = (cnt_q == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      match_q   <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      match_q   <= match_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    match_d   = match_q;
    pv_d      = 1'b0;
    timeout_d = timeout_q;
    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      match_d   = '0;
      timeout_d = 1'b0;
    end else begin
      if (rise_w)
        cnt_d = CNT_W'(1);
      else if (!sat_w)
        cnt_d = cnt_q + CNT_W'(1);
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
          match_d = '0;
        end
        ARM: begin
          match_d = '0;
          if (rise_w)
            state_d = MEAS;
        end
        MEAS: begin
          if (rise_w) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            // match_q == 0 marks the first period after arming
            if (match_q != '0 && cnt_q == period_q) begin
              if (match_q != LOCK_M)
                match_d = match_q + MW'(1);
            end else begin
              match_d = MW'(1);
            end
          end else if (sat_w) begin
            timeout_d = 1'b1;
            match_d   = '0;
            state_d   = ARM;
          end
          if (fall_w && !level_w)
            high_d = cnt_q;
        end
        default: state_d = IDLE;
      endcase
    end
    locked_d = (match_d == LOCK_M);
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter (CNT_W = 8 so saturation is reachable).
`timescale 1ns/100ps
module tb_clk_ratio_meter;
  import clk_meas_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          clk_div_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          locked;
  logic          timeout;

  int n_checks = 0;
  int n_fail   = 0;

  int ev_per[$];
  int ev_ht[$];
  int ev_lock[$];
  bit to_seen;

  clk_ratio_meter #(
    .CNT_W      (CW),
    .SYNC_STAGES(2),
    .LOCK_COUNT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clk_div_in  (clk_div_in),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ev_per.delete();
    ev_ht.delete();
    ev_lock.delete();
    to_seen = 1'b0;
  endtask

  task automatic sample();
    if (period_valid) begin
      ev_per.push_back(int'(period));
      ev_ht.push_back(int'(high_time));
      ev_lock.push_back(int'(locked));
    end
    if (timeout)
      to_seen = 1'b1;
  endtask

  task automatic step(input logic v);
    @(posedge clk);
    #1;
    sample();
    clk_div_in = v;
  endtask

  task automatic hold(input int n, input logic v);
    for (int i = 0; i < n; i++)
      step(v);
  endtask

  task automatic run_div(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      hold(hi, 1'b1);
      hold(lo, 1'b0);
    end
  endtask

  task automatic mon(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      sample();
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    clk_div_in = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;

    // 10 high / 10 low: first rise arms, five reports of 20
    run_div(10, 10, 6);
    chk("d20_count", ev_per.size(), 5);
    chk("d20_per0", ev_per[0], 20);
    chk("d20_ht0", ev_ht[0], 10);
    chk("d20_per4", ev_per[4], 20);
    chk("d20_lock2", ev_lock[2], 0);
    chk("d20_lock3", ev_lock[3], 1);
    chk("d20_timeout", to_seen, 0);

    // switch to 6/6: last 20, then 12 drops lock, relocks on 4th 12
    clr();
    run_div(6, 6, 6);
    chk("d12_count", ev_per.size(), 6);
    chk("d12_per0", ev_per[0], 20);
    chk("d12_lock0", ev_lock[0], 1);
    chk("d12_per1", ev_per[1], 12);
    chk("d12_lock1", ev_lock[1], 0);
    chk("d12_lock3", ev_lock[3], 0);
    chk("d12_lock4", ev_lock[4], 1);
    chk("d12_ht5", ev_ht[5], 6);

    // disable mid-period
    hold(3, 1'b1);
    enable = 1'b0;
    hold(1, 1'b0);
    chk("dis_locked", locked, 0);
    chk("dis_pv", period_valid, 0);
    chk("dis_period", period, 12);
    hold(5, 1'b0);
    enable = 1'b1;
    hold(3, 1'b0);
    clr();
    run_div(6, 6, 3);
    chk("reen_count", ev_per.size(), 2);
    chk("reen_per0", ev_per[0], 12);
    chk("reen_ht0", ev_ht[0], 6);

    // stopped input: saturate at 255
    hold(235, 1'b0);
    chk("sat_pre_to", timeout, 0);
    hold(40, 1'b0);
    chk("sat_to", timeout, 1);
    chk("sat_locked", locked, 0);
    chk("sat_state", 32'(dut.state_q), 32'(ARM));
    clr();
    run_div(10, 10, 6);
    chk("relock_count", ev_per.size(), 5);
    chk("relock_per0", ev_per[0], 20);
    chk("relock_lock3", ev_lock[3], 1);
    chk("relock_to", timeout, 1);
    enable = 1'b0;
    hold(1, 1'b0);
    chk("toggle_to", timeout, 0);
    enable = 1'b1;

    // async reset mid-measurement
    run_div(10, 10, 6);
    chk("pre_rst_lock", locked, 1);
    hold(4, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_period", period, 0);
    chk("arst_high", high_time, 0);
    chk("arst_pv", period_valid, 0);
    clk_div_in = 1'b0;
    hold(3, 1'b0);
    reset = 1'b0;
    clr();
    run_div(10, 10, 4);
    chk("rst_rearm_cnt", ev_per.size(), 3);
    chk("rst_rearm_per", ev_per[0], 20);

    // asynchronous 20.3-cycle input
    clr();
    fork
      begin
        #0.3;
        for (int h = 0; h < 80; h++) begin
          clk_div_in = ~clk_div_in;
          #101.5;
        end
      end
      mon(815);
    join
    chk("async_count_ok", 32'(ev_per.size() >= 35), 1);
    for (int i = 1; i < ev_per.size(); i++)
      chk($sformatf("async_per%0d", i),
          32'(ev_per[i] == 20 || ev_per[i] == 21), 1);
    chk("async_timeout", to_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
